icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch stage and the memory controller. It serves `imemload`/`ihit` to fetch from a one-word-per-frame array, and on a miss it runs a single-word fill from memory. Fetch holds PC while `ihit` is low, so the cache only owns fill sequencing and frame state.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/icache.sv | 79 +++++++
 tb/tb_icache.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address decode, frame layout and fill FSM states.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame, single-word fill on miss.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    icache_frame_t frames [SETS];
    icache_state_t state, next_state;
    logic [31:0]   miss_addr;
    icachef_t      req, miss;
    logic          hit, latch_miss, fill;
    logic          unused_bytoff;

    assign req  = icachef_t'(imemaddr);
    assign miss = icachef_t'(miss_addr);
    assign unused_bytoff = ^{req.bytoff, miss.bytoff};

    assign hit      = frames[req.idx].valid && (frames[req.idx].tag == req.tag);
    assign imemload = frames[req.idx].data;
    assign iaddr    = miss_addr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (latch_miss) begin
                miss_addr <= {imemaddr[31:2], 2'b00};
            end
            if (fill) begin
                frames[miss.idx] <= '{valid: 1'b1, tag: miss.tag, data: iload};
            end
        end
    end

    // iREN is decoded from state alone so memory never sees a combinational path from iwait.
    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        latch_miss = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN & hit;
                if (imemREN && !hit && !halt) begin
                    latch_miss = 1'b1;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table, scoreboard of expected fetch words, corner sequences.
module tb_icache;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit, iREN, iwait;
    logic [31:0] imemload, iaddr, iload;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          w;
        int          iren;
    } vec_t;

    vec_t vt[4];

    always #5 CLK = ~CLK;

    icache #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iload(iload), .iwait(iwait)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2001_0005;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    // Memory model: iwait high for wait_cfg cycles at the start of every read.
    assign iload = mem_word(iaddr);
    assign iwait = (wcnt != 0);
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)        wcnt <= wait_cfg;
        else if (!iREN)   wcnt <= wait_cfg;
        else if (wcnt > 0) wcnt <= wcnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        logic [31:0] e;
        if (nRST === 1'b1 && ihit === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ihit", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("imemload", imemload, e);
            end
        end
    end

    task automatic wait_hit(input logic [31:0] fa, output bit first, output int nren);
        bit ok;
        nren = 0; ok = 0; first = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (c == 0) first = ihit;
            if (iREN) begin
                nren++;
                check("iaddr", iaddr, fa);
            end
            if (ihit) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ihit_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic access(input logic [31:0] a, input bit exp_miss, input int w, input int exp_iren);
        bit first;
        int nren;
        wait_cfg = w;
        imemREN  = 1'b1;
        imemaddr = a;
        sb_q.push_back(mem_word(a));
        wait_hit({a[31:2], 2'b00}, first, nren);
        check($sformatf("first_ihit@%0h", a), {31'b0, first}, {31'b0, !exp_miss});
        check($sformatf("iren_cycles@%0h", a), nren, exp_iren);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bit first;
        int nren, n80, n84, nbad, total;

        vt[0] = '{addr: 32'h0000_0040, miss: 1, w: 3, iren: 4};
        vt[1] = '{addr: 32'h0000_0040, miss: 0, w: 0, iren: 0};
        vt[2] = '{addr: 32'h0000_0440, miss: 1, w: 0, iren: 1};
        vt[3] = '{addr: 32'h0000_0040, miss: 1, w: 0, iren: 1};

        #12;
        check("rst_ihit", {31'b0, ihit}, 32'd0);
        check("rst_iren", {31'b0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        for (int i = 0; i < 4; i++) begin
            access(vt[i].addr, vt[i].miss, vt[i].w, vt[i].iren);
        end

        // Address changes to 0x84 while the 0x80 fill is in flight.
        wait_cfg = 2; imemREN = 1'b1; imemaddr = 32'h80;
        @(posedge CLK); #1;
        imemaddr = 32'h84;
        sb_q.push_back(mem_word(32'h84));
        n80 = 0; n84 = 0; nbad = 0;
        begin : midfill
            bit ok;
            ok = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge CLK);
                if (iREN) begin
                    if (iaddr == 32'h80) n80++;
                    else if (iaddr == 32'h84) n84++;
                    else nbad++;
                end
                if (ihit) begin ok = 1; break; end
            end
            if (!ok) check("midfill_timeout", 32'd0, 32'd1);
        end
        @(posedge CLK); #1;
        check("midfill_iren80", n80, 3);
        check("midfill_iren84", n84, 3);
        check("midfill_badaddr", nbad, 0);
        access(32'h80, 0, 0, 0);
        access(32'h84, 0, 0, 0);

        // Halt blocks a new fill.
        halt = 1'b1; imemaddr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check("halt_iren", {31'b0, iREN}, 32'd0);
            check("halt_ihit", {31'b0, ihit}, 32'd0);
        end
        @(posedge CLK); #1;

        // Halt raised mid-fill does not abort it.
        halt = 1'b0; wait_cfg = 3;
        sb_q.push_back(mem_word(32'h100));
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        halt = 1'b1;
        wait_hit(32'h100, first, nren);
        check("halt_midfill_iren", nren, 3);
        halt = 1'b0;

        // Reset in FETCH drops the fill.
        wait_cfg = 5; imemaddr = 32'h80;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_rst_iren", {31'b0, iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        check("midrst_iren", {31'b0, iREN}, 32'd0);
        check("midrst_iaddr", iaddr, 32'd0);
        check("midrst_ihit", {31'b0, ihit}, 32'd0);
        check("midrst_imemload", imemload, 32'd0);
        sb_q.delete();
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        access(32'h00, 1, 0, 1);
        access(32'h80, 1, 0, 1);

        // Sweep all indices twice: 16 misses, then 16 hits without memory traffic.
        for (int i = 0; i < 16; i++) access(32'(i * 4), 1, 0, 1);
        total = 0;
        for (int i = 0; i < 16; i++) begin
            wait_cfg = 0; imemaddr = 32'(i * 4);
            sb_q.push_back(mem_word(32'(i * 4)));
            wait_hit(32'(i * 4), first, nren);
            check($sformatf("sweep2_hit@%0h", i * 4), {31'b0, first}, 32'd1);
            total += nren;
        end
        check("sweep2_iren_total", total, 0);

        imemREN = 1'b0;
        @(posedge CLK); #1;
        check("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
